rv32_branch_predictor: RTL and testbench
========================================

Name: rv32_branch_predictor

Overview:
Fetch-side counterpart of the execute-stage branch resolver. It predicts taken/target for the fetch PC from a direct-mapped table of 2-bit saturating counters, tags and targets. It trains on resolved outcomes returned from execute (do_branch, target, branch_op) and flags mispredicts back to the pipeline for redirect. It also runs an invalidate sweep FSM and keeps resolve/mispredict counters.

Parameters:
ENTRIES, 16, table depth; power of two, ≥2; IDX_BITS = $clog2(ENTRIES)
TAG_BITS, 8, tag width taken from pc[IDX_BITS+2 +: TAG_BITS]; IDX_BITS+2+TAG_BITS ≤ 32

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
fetch_pc  in  32 (rv32_word)  PC being fetched
pred_taken  out  1  prediction for fetch_pc (combinational from table state)
pred_target  out  32 (rv32_word)  predicted next PC
resolve_valid  in  1  execute reports a resolved branch/jump this cycle
resolve_pc  in  32  PC of the resolved instruction
resolve_op  in  branch_op_t  branch op of the resolved instruction
resolve_taken  in  1  do_branch from the execute-stage resolver
resolve_target  in  32  computed target
resolve_pred_taken  in  1  prediction that travelled down the pipe with the instruction
resolve_pred_target  in  32  target that travelled down the pipe
mispredict  out  1  combinational redirect request
invalidate  in  1  one-cycle pulse; start the table sweep
busy  out  1  sweep in progress
resolve_count  out  32  count of accepted resolves
mispredict_count  out  32  count of mispredicts

Behaviour:
- Index = pc[IDX_BITS+1:2]; tag = pc[IDX_BITS+2 +: TAG_BITS]. Entry fields: valid, tag, ctr[1:0], target.
- Reset (async, resetn=0): all valid=0, FSM=IDLE, sweep index=0, both counters=0, busy=0. Tag, ctr and target are not reset.
- hit = valid[idx] && tag matches. pred_taken = !busy && hit && ctr[1]. pred_target = pred_taken ? target : fetch_pc+4. Lookup has zero latency and no bypass: an update to the same index in the same cycle becomes visible next cycle.
- mispredict = resolve_valid && (resolve_taken != resolve_pred_taken || (resolve_taken && resolve_target != resolve_pred_target)). It is produced even while busy. resolve_op values outside the branch set (i.e. no branch) still count as resolves and are never allocated.
- Training occurs on the clock edge and only when resolve_valid && !busy:
  - Hit with resolve_op == OP_J: ctr=2'b11, target updated.
  - Hit, conditional branch: ctr saturating-increments if taken, else saturating-decrements (3 stays 3, 0 stays 0). Target is written only when taken.
  - Miss and taken: allocate. valid=1, tag, target, ctr=2'b10 (2'b11 for OP_J). Overwrites any conflicting entry.
  - Miss and not taken: no change.
- Counters: resolve_count += 1 for every resolve_valid cycle, including while busy. mispredict_count += 1 when mispredict=1. Both wrap 0xFFFFFFFF→0.
- FSM:
  - IDLE: on invalidate go to CLEAR with sweep index=0.
  - CLEAR: valid[sweep]=0 each cycle, sweep index +1; after index ENTRIES-1 return to IDLE. busy=1 throughout CLEAR, so the sweep takes exactly ENTRIES cycles.
  - invalidate asserted during CLEAR restarts the sweep at index 0.
  - Training is suppressed during CLEAR.
- Reset mid-sweep: immediate return to IDLE with all valid=0.

Decomposition:
- Shared rv32 package: branch_op_t (existing), 2-bit counter typedef, constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3, bp_state_t {BP_IDLE, BP_CLEAR}.
- One sub-module, rv32_sat_counter2: combinational next-counter from (ctr, taken, force_strong).
- Table storage stays inline as arrays.

Test Plan:
- Reset then fetch_pc=0x100 → pred_taken=0, pred_target=0x104, busy=0, counters=0.
- Resolve pc=0x100, OP_BEQ, taken, target=0x80, pred_taken=0 → mispredict=1, mispredict_count=1. Next cycle fetch 0x100 → pred_taken=1, pred_target=0x80 (ctr=2).
- Two not-taken BNE resolves at 0x100 after the above → ctr 2→1→0, pred_taken=0. A third not-taken leaves ctr=0, mispredict=0 when pred_taken=0 is supplied.
- Alias: with ENTRIES=16, TAG_BITS=8, taken resolve at 0x140 (same index as 0x100, different tag) → 0x100 now misses; 0x140 predicts its own target.
- OP_J at 0x200, target 0x300 → ctr=3. Same-cycle fetch of 0x200 → pred_taken=0 (no bypass); next cycle → 0x300.
- invalidate with 16 entries → busy=1 for exactly 16 cycles and training is ignored, but resolve_count still increments. invalidate again at cycle 5 → busy lasts 16 more cycles. Afterwards all lookups miss. Deasserting resetn at cycle 3 → busy=0 immediately.

Source files
------------

// File: rtl/rv32_branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: branch op encoding,
// 2-bit confidence counter and sweep FSM states.
package rv32_branch_predictor_pkg;

  typedef logic [31:0] rv32_word;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BLT  = 4'd3,
    OP_BGE  = 4'd4,
    OP_BLTU = 4'd5,
    OP_BGEU = 4'd6,
    OP_J    = 4'd7
  } branch_op_t;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_SNT = 2'd0;
  localparam ctr2_t CTR_WNT = 2'd1;
  localparam ctr2_t CTR_WT  = 2'd2;
  localparam ctr2_t CTR_ST  = 2'd3;

  typedef logic [0:0] bp_state_t;

  localparam bp_state_t BP_IDLE  = 1'b0;
  localparam bp_state_t BP_CLEAR = 1'b1;

  // Ops that the predictor learns from; anything else is resolved but ignored.
  function automatic logic is_branch_op(input branch_op_t op);
    logic r;
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_J: r = 1'b1;
      default:                                                r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32_sat_counter2.sv
// Next-state function of a 2-bit saturating confidence counter; a forced
// update (unconditional jump) pins the counter at strongly-taken.
module rv32_sat_counter2
  import rv32_branch_predictor_pkg::*;
(
  input  ctr2_t i_ctr,
  input  logic  i_taken,
  input  logic  i_force_strong,
  output ctr2_t o_next
);

  // Saturating step, or force to strongly-taken
  always_comb begin
    o_next = i_ctr;
    if (i_force_strong) begin
      o_next = CTR_ST;
    end else begin
      case (i_ctr)
        CTR_SNT: o_next = i_taken ? CTR_WNT : CTR_SNT;
        CTR_WNT: o_next = i_taken ? CTR_WT  : CTR_SNT;
        CTR_WT:  o_next = i_taken ? CTR_ST  : CTR_WNT;
        CTR_ST:  o_next = i_taken ? CTR_ST  : CTR_WT;
        default: o_next = CTR_SNT;
      endcase
    end
  end

endmodule

// File: rtl/rv32_branch_predictor.sv
// Direct-mapped fetch-side predictor trained by resolved branches from execute.
// Provides zero-latency lookup, mispredict flagging, invalidate sweep and stats.
module rv32_branch_predictor
  import rv32_branch_predictor_pkg::*;
#(
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 8
)
(
  input  logic        clk,
  input  logic        resetn,
  input  rv32_word    fetch_pc,
  output logic        pred_taken,
  output rv32_word    pred_target,
  input  logic        resolve_valid,
  input  rv32_word    resolve_pc,
  input  branch_op_t  resolve_op,
  input  logic        resolve_taken,
  input  rv32_word    resolve_target,
  input  logic        resolve_pred_taken,
  input  rv32_word    resolve_pred_target,
  output logic        mispredict,
  input  logic        invalidate,
  output logic        busy,
  output logic [31:0] resolve_count,
  output logic [31:0] mispredict_count
);

  localparam int IDX_BITS = $clog2(ENTRIES);

  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [TAG_BITS-1:0] tag_t;

  localparam idx_t SWEEP_LAST = idx_t'(ENTRIES - 1);

  logic [ENTRIES-1:0] r_valid;
  tag_t               r_tag    [ENTRIES];
  ctr2_t              r_ctr    [ENTRIES];
  rv32_word           r_target [ENTRIES];

  bp_state_t   r_state;
  idx_t        r_sweep;
  logic [31:0] r_resolve_count;
  logic [31:0] r_mispredict_count;

  idx_t  w_fetch_idx;
  tag_t  w_fetch_tag;
  idx_t  w_res_idx;
  tag_t  w_res_tag;
  logic  w_busy;
  logic  w_fetch_hit;
  logic  w_pred_taken;
  logic  w_mispredict;
  logic  w_res_hit;
  logic  w_train;
  logic  w_is_jump;
  logic  w_upd_hit;
  logic  w_alloc;
  logic  w_wr_target;
  ctr2_t w_ctr_next;
  ctr2_t w_new_ctr;
  logic  w_unused_pc;

  assign w_fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign w_fetch_tag = fetch_pc[IDX_BITS+2 +: TAG_BITS];
  assign w_res_idx   = resolve_pc[IDX_BITS+1:2];
  assign w_res_tag   = resolve_pc[IDX_BITS+2 +: TAG_BITS];
  assign w_unused_pc = ^resolve_pc;

  assign w_busy = (r_state == BP_CLEAR);

  // Lookup reads the registered table directly, so same-cycle updates are not bypassed
  assign w_fetch_hit  = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
  assign w_pred_taken = !w_busy && w_fetch_hit && r_ctr[w_fetch_idx][1];

  assign w_mispredict = resolve_valid &&
                        ((resolve_taken != resolve_pred_taken) ||
                         (resolve_taken && (resolve_target != resolve_pred_target)));

  assign w_res_hit   = r_valid[w_res_idx] && (r_tag[w_res_idx] == w_res_tag);
  assign w_train     = resolve_valid && !w_busy && is_branch_op(resolve_op);
  assign w_is_jump   = (resolve_op == OP_J);
  assign w_upd_hit   = w_train && w_res_hit;
  assign w_alloc     = w_train && !w_res_hit && resolve_taken;
  assign w_wr_target = (w_upd_hit && (resolve_taken || w_is_jump)) || w_alloc;

  rv32_sat_counter2 u_ctr_next (
    .i_ctr          (r_ctr[w_res_idx]),
    .i_taken        (resolve_taken),
    .i_force_strong (w_is_jump),
    .o_next         (w_ctr_next)
  );

  // New allocations start weakly-taken, jumps strongly-taken
  always_comb begin
    w_new_ctr = w_ctr_next;
    if (w_alloc) begin
      if (w_is_jump) begin
        w_new_ctr = CTR_ST;
      end else begin
        w_new_ctr = CTR_WT;
      end
    end else begin
      w_new_ctr = w_ctr_next;
    end
  end

  // Table payload: tag, counter and target carry no reset, gated by valid
  always_ff @(posedge clk) begin
    if (w_upd_hit || w_alloc) begin
      r_tag[w_res_idx] <= w_res_tag;
      r_ctr[w_res_idx] <= w_new_ctr;
    end
    if (w_wr_target) begin
      r_target[w_res_idx] <= resolve_target;
    end
  end

  // Sweep FSM and valid bits; a new invalidate during CLEAR restarts at entry 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= BP_IDLE;
      r_sweep <= {IDX_BITS{1'b0}};
      r_valid <= {ENTRIES{1'b0}};
    end else begin
      case (r_state)
        BP_IDLE: begin
          if (w_alloc) begin
            r_valid[w_res_idx] <= 1'b1;
          end
          if (invalidate) begin
            r_state <= BP_CLEAR;
            r_sweep <= {IDX_BITS{1'b0}};
          end
        end
        BP_CLEAR: begin
          r_valid[r_sweep] <= 1'b0;
          if (invalidate) begin
            r_sweep <= {IDX_BITS{1'b0}};
          end else if (r_sweep == SWEEP_LAST) begin
            r_state <= BP_IDLE;
            r_sweep <= {IDX_BITS{1'b0}};
          end else begin
            r_sweep <= r_sweep + idx_t'(1);
          end
        end
        default: begin
          r_state <= BP_IDLE;
          r_sweep <= {IDX_BITS{1'b0}};
        end
      endcase
    end
  end

  // Resolve and mispredict statistics, counting even while sweeping
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resolve_count    <= 32'd0;
      r_mispredict_count <= 32'd0;
    end else begin
      if (resolve_valid) begin
        r_resolve_count <= r_resolve_count + 32'd1;
      end
      if (w_mispredict) begin
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end
    end
  end

  assign pred_taken       = w_pred_taken;
  assign pred_target      = w_pred_taken ? r_target[w_fetch_idx] : (fetch_pc + 32'd4);
  assign mispredict       = w_mispredict;
  assign busy             = w_busy;
  assign resolve_count    = r_resolve_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_rv32_branch_predictor.sv
// Scoreboard bench: driver pushes reference-model expectations per cycle,
// monitor pops and compares on the falling edge.
module tb_rv32_branch_predictor;
  import rv32_branch_predictor_pkg::*;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        resetn;
  rv32_word    fetch_pc;
  logic        pred_taken;
  rv32_word    pred_target;
  logic        resolve_valid;
  rv32_word    resolve_pc;
  branch_op_t  resolve_op;
  logic        resolve_taken;
  rv32_word    resolve_target;
  logic        resolve_pred_taken;
  rv32_word    resolve_pred_target;
  logic        mispredict;
  logic        invalidate;
  logic        busy;
  logic [31:0] resolve_count;
  logic [31:0] mispredict_count;

  always #5 clk = ~clk;

  rv32_branch_predictor #(.ENTRIES(16), .TAG_BITS(8)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .fetch_pc            (fetch_pc),
    .pred_taken          (pred_taken),
    .pred_target         (pred_target),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_op          (resolve_op),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .mispredict          (mispredict),
    .invalidate          (invalidate),
    .busy                (busy),
    .resolve_count       (resolve_count),
    .mispredict_count    (mispredict_count)
  );

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic        bsy;
    logic [31:0] rc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: plain arrays plus a "cycles of sweep remaining" count
  bit          m_valid [N];
  logic [7:0]  m_tag   [N];
  int          m_ctr   [N];
  logic [31:0] m_tgt   [N];
  int          clear_left = 0;
  logic [31:0] m_rc = 32'd0;
  logic [31:0] m_mc = 32'd0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % 32'(N));
  endfunction

  function automatic logic [7:0] tag_of(input logic [31:0] pc);
    logic [31:0] q;
    q = (pc / 32'(4 * N)) % 32'd256;
    return q[7:0];
  endfunction

  function automatic bit op_learns(input branch_op_t op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_BGE) ||
           (op == OP_BLTU) || (op == OP_BGEU) || (op == OP_J);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      vectors++;
      check("pred_taken",       32'(pred_taken),  32'(e.pt));
      check("pred_target",      pred_target,      e.ptgt);
      check("mispredict",       32'(mispredict),  32'(e.mp));
      check("busy",             32'(busy),        32'(e.bsy));
      check("resolve_count",    resolve_count,    e.rc);
      check("mispredict_count", mispredict_count, e.mc);
    end
  end

  task automatic cyc(input bit rst, input logic [31:0] fpc, input bit rv,
                     input logic [31:0] rpc, input branch_op_t op, input bit rt,
                     input logic [31:0] rtgt, input bit rpt, input logic [31:0] rptgt,
                     input bit inv);
    exp_t e;
    int   i;
    int   t;
    bit   hit;
    @(posedge clk);
    #1;
    resetn              = rst;
    fetch_pc            = fpc;
    resolve_valid       = rv;
    resolve_pc          = rpc;
    resolve_op          = op;
    resolve_taken       = rt;
    resolve_target      = rtgt;
    resolve_pred_taken  = rpt;
    resolve_pred_target = rptgt;
    invalidate          = inv;
    if (!rst) begin
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
      clear_left = 0;
      m_rc = 32'd0;
      m_mc = 32'd0;
    end
    i     = idx_of(fpc);
    e.bsy = (clear_left > 0);
    e.pt  = !e.bsy && m_valid[i] && (m_tag[i] == tag_of(fpc)) && (m_ctr[i] >= 2);
    e.ptgt = e.pt ? m_tgt[i] : (fpc + 32'd4);
    e.mp  = rv && ((rt != rpt) || (rt && (rtgt != rptgt)));
    e.rc  = m_rc;
    e.mc  = m_mc;
    sb_q.push_back(e);
    if (rst) begin
      if (rv) m_rc = m_rc + 32'd1;
      if (e.mp) m_mc = m_mc + 32'd1;
      if (rv && !e.bsy && op_learns(op)) begin
        t   = idx_of(rpc);
        hit = m_valid[t] && (m_tag[t] == tag_of(rpc));
        if (hit) begin
          if (op == OP_J) begin
            m_ctr[t] = 3;
            m_tgt[t] = rtgt;
          end else if (rt) begin
            if (m_ctr[t] < 3) m_ctr[t] = m_ctr[t] + 1;
            m_tgt[t] = rtgt;
          end else begin
            if (m_ctr[t] > 0) m_ctr[t] = m_ctr[t] - 1;
          end
        end else if (rt) begin
          m_valid[t] = 1'b1;
          m_tag[t]   = tag_of(rpc);
          m_tgt[t]   = rtgt;
          m_ctr[t]   = (op == OP_J) ? 3 : 2;
        end
      end
      if (clear_left > 0) begin
        m_valid[N - clear_left] = 1'b0;
        clear_left--;
      end
      if (inv) clear_left = N;
    end
  endtask

  task automatic idle(input logic [31:0] fpc);
    cyc(1'b1, fpc, 1'b0, 32'd0, OP_NONE, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic res(input logic [31:0] fpc, input logic [31:0] rpc, input branch_op_t op,
                     input bit rt, input logic [31:0] rtgt, input bit rpt,
                     input logic [31:0] rptgt);
    cyc(1'b1, fpc, 1'b1, rpc, op, rt, rtgt, rpt, rptgt, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rpc;
    logic [31:0] fpc;
    logic [31:0] rtgt;
    logic [31:0] rptgt;
    branch_op_t  op;
    bit          rt;
    bit          rpt;
    bit          rv;
    bit          inv;
    bit          rst;

    resetn = 1'b0; fetch_pc = 32'd0; resolve_valid = 1'b0; resolve_pc = 32'd0;
    resolve_op = OP_NONE; resolve_taken = 1'b0; resolve_target = 32'd0;
    resolve_pred_taken = 1'b0; resolve_pred_target = 32'd0; invalidate = 1'b0;

    // Reset state and first lookup
    cyc(1'b0, 32'h100, 1'b0, 32'd0, OP_NONE, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 32'h100, 1'b0, 32'd0, OP_NONE, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(32'h100);

    // Allocate on taken miss, then train down to strongly-not-taken
    res(32'h100, 32'h100, OP_BEQ, 1'b1, 32'h80, 1'b0, 32'h0);
    idle(32'h100);
    res(32'h100, 32'h100, OP_BNE, 1'b0, 32'h0, 1'b1, 32'h80);
    res(32'h100, 32'h100, OP_BNE, 1'b0, 32'h0, 1'b1, 32'h80);
    idle(32'h100);
    res(32'h100, 32'h100, OP_BNE, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);

    // Alias on index 0 with a different tag
    res(32'h100, 32'h140, OP_BLT, 1'b1, 32'h500, 1'b0, 32'h0);
    idle(32'h100);
    idle(32'h140);

    // Jump: no same-cycle bypass, visible next cycle
    res(32'h200, 32'h200, OP_J, 1'b1, 32'h300, 1'b1, 32'h304);
    idle(32'h200);
    res(32'h200, 32'h200, OP_NONE, 1'b1, 32'h700, 1'b1, 32'h700);
    idle(32'h200);

    // Sweep with a restart on its fifth cycle; resolves still counted
    cyc(1'b1, 32'h200, 1'b0, 32'd0, OP_NONE, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    for (int k = 0; k < 24; k++) begin
      cyc(1'b1, 32'h200, (k <= 20), 32'h204, OP_BEQ, 1'b1, 32'h900, 1'b0, 32'h0, (k == 4));
    end
    idle(32'h204);
    idle(32'h140);

    // Reset in the middle of a sweep
    res(32'h300, 32'h300, OP_BGE, 1'b1, 32'h40, 1'b0, 32'h0);
    cyc(1'b1, 32'h300, 1'b0, 32'd0, OP_NONE, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    idle(32'h300);
    idle(32'h300);
    cyc(1'b0, 32'h300, 1'b0, 32'd0, OP_NONE, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    idle(32'h300);

    // Randomised traffic over a small PC pool so hits and aliases are common
    for (int n = 0; n < 2000; n++) begin
      rpc   = (32'($urandom_range(4, 7)) << 6) | (32'($urandom_range(0, 15)) << 2);
      fpc   = ($urandom_range(0, 3) == 0) ? rpc
            : ((32'($urandom_range(4, 7)) << 6) | (32'($urandom_range(0, 15)) << 2));
      op    = branch_op_t'(4'($urandom_range(0, 7)));
      rt    = ($urandom_range(0, 1) == 1);
      rpt   = ($urandom_range(0, 1) == 1);
      rtgt  = 32'h1000 + (32'($urandom_range(0, 7)) << 2);
      rptgt = ($urandom_range(0, 1) == 1) ? rtgt : (32'h1000 + (32'($urandom_range(0, 7)) << 2));
      rv    = ($urandom_range(0, 3) != 0);
      inv   = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 499) != 0);
      cyc(rst, fpc, rv, rpc, op, rt, rtgt, rpt, rptgt, inv);
    end

    for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
